// File: rtl/pipeline_risk_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/flush/halt controller.
package pipeline_risk_ctrl_pkg;

  localparam int         DRAIN_CYCLES = 3;
  localparam int         DRAIN_W      = 2;
  localparam logic [4:0] ZERO_REG     = 5'd0;
  localparam int         CNT_W        = 16;

  typedef enum logic [1:0] {
    S_RUN       = 2'd0,
    S_STEP_WAIT = 2'd1,
    S_DRAIN     = 2'd2,
    S_HALTED    = 2'd3
  } state_t;

  // Event counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/pipeline_risk_ctrl_load_use_detect.sv
// Load-use hazard compare: a load in EX writes a register the ID instruction reads.
module load_use_detect
  import pipeline_risk_ctrl_pkg::*;
(
  input  logic       i_ex_mem_read,
  input  logic [4:0] i_ex_rt,
  input  logic [4:0] i_id_rs,
  input  logic [4:0] i_id_rt,
  output logic       o_hit
);

  // Register zero is hardwired, so a load targeting it never creates a dependency.
  assign o_hit = i_ex_mem_read && (i_ex_rt != ZERO_REG) &&
                 ((i_ex_rt == i_id_rs) || (i_ex_rt == i_id_rt));

endmodule

// File: rtl/pipeline_risk_ctrl.sv
// Pipeline hazard controller: load-use stall, branch/jump flush, halt drain and debug single-step.
module pipeline_risk_ctrl
  import pipeline_risk_ctrl_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [4:0]       i_id_rs,
  input  logic [4:0]       i_id_rt,
  input  logic             i_ex_mem_read,
  input  logic [4:0]       i_ex_rt,
  input  logic             i_ex_branch_taken,
  input  logic             i_id_jump,
  input  logic             i_id_halt,
  input  logic             i_debug_mode,
  input  logic             i_debug_step,
  output logic             o_risk,
  output logic             o_pc_write,
  output logic             o_if_id_write,
  output logic             o_if_id_flush,
  output logic             o_pipe_en,
  output logic             o_halted,
  output logic [CNT_W-1:0] o_stall_cnt,
  output logic [CNT_W-1:0] o_flush_cnt,
  output state_t           o_dbg_state
);

  state_t             state;
  logic [DRAIN_W-1:0] drain_cnt;
  logic               step_q;
  logic               step_rise;
  logic               active;
  logic               load_use;
  logic               stall_ev;
  logic               flush_ev;
  logic               halt_ev;

  load_use_detect u_load_use_detect (
    .i_ex_mem_read (i_ex_mem_read),
    .i_ex_rt       (i_ex_rt),
    .i_id_rs       (i_id_rs),
    .i_id_rt       (i_id_rt),
    .o_hit         (load_use)
  );

  // A held step request only counts on its rising edge.
  assign step_rise = i_debug_step && !step_q;
  assign active    = (state == S_RUN) || ((state == S_STEP_WAIT) && step_rise);

  always_comb begin
    o_risk        = 1'b0;
    o_pc_write    = 1'b0;
    o_if_id_write = 1'b0;
    o_if_id_flush = 1'b0;
    o_pipe_en     = 1'b0;
    o_halted      = 1'b0;
    stall_ev      = 1'b0;
    flush_ev      = 1'b0;
    halt_ev       = 1'b0;
    if (i_reset) begin
      o_risk = 1'b1;
    end else begin
      case (state)
        S_RUN, S_STEP_WAIT: begin
          if (active) begin
            if (i_ex_branch_taken) begin
              o_risk        = 1'b1;
              o_pc_write    = 1'b1;
              o_if_id_write = 1'b1;
              o_if_id_flush = 1'b1;
              o_pipe_en     = 1'b1;
              flush_ev      = 1'b1;
            end else if (load_use) begin
              o_risk    = 1'b1;
              o_pipe_en = 1'b1;
              stall_ev  = 1'b1;
            end else begin
              o_pc_write    = 1'b1;
              o_if_id_write = 1'b1;
              o_pipe_en     = 1'b1;
              o_if_id_flush = i_id_jump;
              flush_ev      = i_id_jump;
              halt_ev       = i_id_halt;
            end
          end
        end
        // Front end frozen, bubbles pushed so older instructions retire.
        S_DRAIN: begin
          o_risk    = 1'b1;
          o_pipe_en = 1'b1;
        end
        S_HALTED: begin
          o_risk   = 1'b1;
          o_halted = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state       <= S_RUN;
      drain_cnt   <= '0;
      step_q      <= 1'b0;
      o_stall_cnt <= '0;
      o_flush_cnt <= '0;
    end else begin
      step_q <= i_debug_step;
      if (stall_ev) o_stall_cnt <= sat_inc(o_stall_cnt);
      if (flush_ev) o_flush_cnt <= sat_inc(o_flush_cnt);
      case (state)
        S_RUN, S_STEP_WAIT: begin
          if (halt_ev) begin
            state     <= S_DRAIN;
            drain_cnt <= DRAIN_W'(DRAIN_CYCLES);
          end else if ((state == S_RUN) && i_debug_mode) begin
            state <= S_STEP_WAIT;
          end else if ((state == S_STEP_WAIT) && !i_debug_mode) begin
            state <= S_RUN;
          end
        end
        S_DRAIN: begin
          if (drain_cnt != '0) drain_cnt <= drain_cnt - 1'b1;
          if (drain_cnt <= DRAIN_W'(1)) state <= S_HALTED;
        end
        S_HALTED: ;
        default: state <= S_RUN;
      endcase
    end
  end

  assign o_dbg_state = state;

endmodule

// File: tb/tb_pipeline_risk_ctrl.sv
// Directed bench for pipeline_risk_ctrl with a control-vector scoreboard.
module tb_pipeline_risk_ctrl;
  import pipeline_risk_ctrl_pkg::*;

  // Control vector order: {risk, pc_write, if_id_write, if_id_flush, pipe_en, halted}
  localparam logic [5:0] CTL_RESET  = 6'b100000;
  localparam logic [5:0] CTL_NORM   = 6'b011010;
  localparam logic [5:0] CTL_STALL  = 6'b100010;
  localparam logic [5:0] CTL_BRANCH = 6'b111110;
  localparam logic [5:0] CTL_JUMP   = 6'b011110;
  localparam logic [5:0] CTL_DRAIN  = 6'b100010;
  localparam logic [5:0] CTL_HALTED = 6'b100001;
  localparam logic [5:0] CTL_IDLE   = 6'b000000;

  logic             i_clk = 1'b0;
  logic             i_reset;
  logic [4:0]       i_id_rs, i_id_rt, i_ex_rt;
  logic             i_ex_mem_read, i_ex_branch_taken, i_id_jump, i_id_halt;
  logic             i_debug_mode, i_debug_step;
  logic             o_risk, o_pc_write, o_if_id_write, o_if_id_flush, o_pipe_en, o_halted;
  logic [CNT_W-1:0] o_stall_cnt, o_flush_cnt;
  state_t           o_dbg_state;

  logic [5:0] exp_q[$];
  string      tag_q[$];
  int         n_cmp  = 0;
  int         n_fail = 0;
  int         pcw_seen;
  logic [5:0] obs;

  pipeline_risk_ctrl dut (
    .i_clk             (i_clk),
    .i_reset           (i_reset),
    .i_id_rs           (i_id_rs),
    .i_id_rt           (i_id_rt),
    .i_ex_mem_read     (i_ex_mem_read),
    .i_ex_rt           (i_ex_rt),
    .i_ex_branch_taken (i_ex_branch_taken),
    .i_id_jump         (i_id_jump),
    .i_id_halt         (i_id_halt),
    .i_debug_mode      (i_debug_mode),
    .i_debug_step      (i_debug_step),
    .o_risk            (o_risk),
    .o_pc_write        (o_pc_write),
    .o_if_id_write     (o_if_id_write),
    .o_if_id_flush     (o_if_id_flush),
    .o_pipe_en         (o_pipe_en),
    .o_halted          (o_halted),
    .o_stall_cnt       (o_stall_cnt),
    .o_flush_cnt       (o_flush_cnt),
    .o_dbg_state       (o_dbg_state)
  );

  // Clock / reset
  always #5 i_clk = ~i_clk;

  // Driver tasks
  task automatic set_in(input logic [4:0] rs, input logic [4:0] rt, input logic mr,
                        input logic [4:0] ert, input logic br, input logic jmp,
                        input logic hlt, input logic dm, input logic ds);
    i_id_rs = rs; i_id_rt = rt; i_ex_mem_read = mr; i_ex_rt = ert;
    i_ex_branch_taken = br; i_id_jump = jmp; i_id_halt = hlt;
    i_debug_mode = dm; i_debug_step = ds;
  endtask

  // Push the expected control vector, sample at the falling edge, then advance one clock.
  task automatic cycle(input string tag, input logic [5:0] exp_ctl, output logic [5:0] seen);
    logic [5:0] e;
    string      t;
    exp_q.push_back(exp_ctl);
    tag_q.push_back(tag);
    @(negedge i_clk);
    seen = {o_risk, o_pc_write, o_if_id_write, o_if_id_flush, o_pipe_en, o_halted};
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    n_cmp++;
    assert (seen === e) else begin
      n_fail++;
      $error("FAIL %s: observed ctl=%b expected ctl=%b", t, seen, e);
    end
    @(posedge i_clk);
    #1;
  endtask

  task automatic check_cnt(input string tag, input logic [CNT_W-1:0] es, input logic [CNT_W-1:0] ef);
    n_cmp++;
    assert (o_stall_cnt === es && o_flush_cnt === ef) else begin
      n_fail++;
      $error("FAIL %s: observed stall=%0d flush=%0d expected stall=%0d flush=%0d",
             tag, o_stall_cnt, o_flush_cnt, es, ef);
    end
  endtask

  task automatic check_state(input string tag, input state_t es);
    n_cmp++;
    assert (o_dbg_state === es) else begin
      n_fail++;
      $error("FAIL %s: observed state=%0d expected state=%0d", tag, o_dbg_state, es);
    end
  endtask

  initial begin
    i_reset = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle("reset0", CTL_RESET, obs);
    cycle("reset1", CTL_RESET, obs);
    check_cnt("reset_cnt", 0, 0);
    check_state("reset_state", S_RUN);
    i_reset = 1'b0;

    cycle("idle", CTL_NORM, obs);
    // Load-use via rs, then via rt
    set_in(5, 1, 1, 5, 0, 0, 0, 0, 0);
    cycle("ld_use_rs", CTL_STALL, obs);
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    check_cnt("ld_use_rs_cnt", 1, 0);
    cycle("after_ld_rs", CTL_NORM, obs);
    set_in(3, 5, 1, 5, 0, 0, 0, 0, 0);
    cycle("ld_use_rt", CTL_STALL, obs);
    check_cnt("ld_use_rt_cnt", 2, 0);
    set_in(5, 5, 0, 5, 0, 0, 0, 0, 0);
    cycle("no_load", CTL_NORM, obs);
    check_cnt("no_load_cnt", 2, 0);

    i_reset = 1'b1;
    cycle("reset2", CTL_RESET, obs);
    i_reset = 1'b0;
    check_cnt("reset2_cnt", 0, 0);
    set_in(0, 0, 1, 0, 0, 0, 0, 0, 0);
    cycle("ld_rt_zero", CTL_NORM, obs);
    check_cnt("ld_rt_zero_cnt", 0, 0);
    set_in(7, 0, 1, 7, 1, 0, 0, 0, 0);
    cycle("branch_over_ld", CTL_BRANCH, obs);
    check_cnt("branch_over_ld_cnt", 0, 1);
    set_in(0, 0, 0, 0, 0, 1, 0, 0, 0);
    cycle("jump", CTL_JUMP, obs);
    check_cnt("jump_cnt", 0, 2);
    set_in(0, 4, 1, 4, 0, 1, 0, 0, 0);
    cycle("stall_over_jump", CTL_STALL, obs);
    check_cnt("stall_over_jump_cnt", 1, 2);
    set_in(0, 0, 0, 0, 1, 0, 1, 0, 0);
    cycle("branch_over_halt", CTL_BRANCH, obs);
    check_cnt("branch_over_halt_cnt", 1, 3);
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle("no_halt_after_branch", CTL_NORM, obs);

    // Single step: a held step request gives one active cycle
    set_in(0, 0, 0, 0, 0, 0, 0, 1, 0);
    cycle("dbg_enter_run", CTL_NORM, obs);
    check_state("dbg_state", S_STEP_WAIT);
    cycle("dbg_wait", CTL_IDLE, obs);
    pcw_seen = 0;
    for (int i = 0; i < 7; i++) begin
      i_debug_step = (i < 5);
      cycle("dbg_step_held", (i == 0) ? CTL_NORM : CTL_IDLE, obs);
      if (obs[4]) pcw_seen++;
    end
    n_cmp++;
    assert (pcw_seen == 1) else begin
      n_fail++;
      $error("FAIL dbg_pc_write_count: observed %0d expected 1", pcw_seen);
    end
    set_in(9, 0, 1, 9, 0, 0, 0, 1, 1);
    cycle("dbg_step_stall", CTL_STALL, obs);
    set_in(0, 0, 0, 0, 0, 0, 0, 1, 1);
    cycle("dbg_step_held2", CTL_IDLE, obs);
    check_cnt("dbg_cnt", 2, 3);
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle("dbg_exit", CTL_IDLE, obs);
    cycle("dbg_back_run", CTL_NORM, obs);

    // Halt drain; debug mode asserted during drain is ignored
    set_in(0, 0, 0, 0, 0, 0, 1, 0, 0);
    cycle("halt_issue", CTL_NORM, obs);
    set_in(0, 0, 0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) cycle("drain", CTL_DRAIN, obs);
    set_in(0, 0, 0, 0, 1, 1, 0, 0, 0);
    for (int i = 0; i < 11; i++) cycle("halted", CTL_HALTED, obs);
    check_cnt("halted_cnt", 2, 3);
    check_state("halted_state", S_HALTED);

    // Reset in the middle of drain
    i_reset = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle("reset3", CTL_RESET, obs);
    i_reset = 1'b0;
    set_in(6, 0, 1, 6, 0, 0, 0, 0, 0);
    cycle("pre_drain_stall", CTL_STALL, obs);
    set_in(0, 0, 0, 0, 0, 0, 1, 0, 0);
    cycle("halt_issue2", CTL_NORM, obs);
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle("drain_first", CTL_DRAIN, obs);
    i_reset = 1'b1;
    cycle("reset_mid_drain", CTL_RESET, obs);
    i_reset = 1'b0;
    check_state("mid_drain_state", S_RUN);
    check_cnt("mid_drain_cnt", 0, 0);
    cycle("run_after_reset", CTL_NORM, obs);
    cycle("run_after_reset2", CTL_NORM, obs);

    // Stall counter saturation
    set_in(8, 0, 1, 8, 0, 0, 0, 0, 0);
    repeat (65534) @(posedge i_clk);
    #1;
    check_cnt("sat_below", 16'hFFFE, 0);
    @(posedge i_clk);
    #1;
    check_cnt("sat_reach", 16'hFFFF, 0);
    repeat (3) @(posedge i_clk);
    #1;
    check_cnt("sat_hold", 16'hFFFF, 0);
    cycle("sat_stall_ctl", CTL_STALL, obs);
    check_cnt("sat_hold2", 16'hFFFF, 0);

    n_cmp++;
    assert (exp_q.size() == 0) else begin
      n_fail++;
      $error("FAIL scoreboard_drain: observed %0d left expected 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
